cdb_arbiter: RTL

//  Shares the single common data bus (CDB) between the Tomasulo functional-unit groups
//  (muldiv, cal, ls). Each requester pushes finished (label, data) results into a private FIFO.
//  A round-robin scheduler pops at most one result per cycle into a registered cdb_entry.master.

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_arbiter_if.sv | 12 +
 rtl/cdb_req_fifo.sv | 54 +++++
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: requester count, tag width and the (label, data) result record.
// Reservation stations and the CDB arbiter both import this package.
package cdb_arbiter_pkg;

  localparam int N_RES_STAT     = 16;
  localparam int N_REQ_CDB      = 3;   // 0 = muldiv, 1 = cal, 2 = ls
  localparam int CDB_FIFO_DEPTH = 2;
  localparam int LABEL_W        = $clog2(N_RES_STAT);
  localparam int DATA_W         = 32;

  typedef struct packed {
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0]  data;
  } cdb_req_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Common data bus broadcast: one registered (valid, label, data) result per cycle.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic               valid;
  logic [LABEL_W-1:0] label;
  logic [DATA_W-1:0]  data;

  modport master (output valid, output label, output data);
  modport slave  (input  valid, input  label, input  data);

endinterface

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO; flush empties it and discards same-cycle push/pop.
module cdb_req_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = CDB_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     push,
  input  logic     pop,
  input  cdb_req_t din,
  output logic     full,
  output logic     empty,
  output cdb_req_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_en;
  logic        rd_en;
  cdb_req_t    mem [DEPTH];

  // The extra pointer MSB tells a wrapped (full) writer from an equal (empty) one.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign wr_en = push && !full && !flush;
  assign rd_en = pop && !empty && !flush;

  // NOTE: state flops use <= so every flop samples pre-edge values; = would chain updates within one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: payload storage has no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between the functional-unit groups.
// Each requester queues results in a private FIFO; one winner per cycle is registered onto the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ      = N_REQ_CDB,
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ-1:0][LABEL_W-1:0]   req_label,
  input  logic [N_REQ-1:0][DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]                req_ready,
  cdb_arbiter_if.master                   cdb
);

  localparam int REQ_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int N_TAG = 1 << LABEL_W;

  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;
  logic [N_REQ-1:0] full;
  logic [N_REQ-1:0] empty;
  cdb_req_t         fifo_din  [N_REQ];
  cdb_req_t         fifo_head [N_REQ];

  logic [REQ_W-1:0] rr_ptr;
  logic [REQ_W-1:0] rr_next;
  logic [REQ_W-1:0] cand;
  logic [REQ_W-1:0] grant_idx;
  logic             grant_valid;
  cdb_req_t         winner;

  logic [N_TAG-1:0] label_pend;
  logic [N_TAG-1:0] label_pend_next;

  // Ready is a pure decode of the full flag, independent of any same-cycle pop.
  assign req_ready = ~full;

  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    assign push[i]     = req_valid[i] && req_ready[i];
    assign pop[i]      = grant_valid && (grant_idx == REQ_W'(i));
    assign fifo_din[i] = cdb_req_t'{label: req_label[i], data: req_data[i]};

    cdb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (fifo_din[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (fifo_head[i])
    );
  end

  // Scan rr_ptr, rr_ptr+1, ... downwards so the closest non-empty FIFO is assigned last and wins.
  // NOTE: every variable gets a default before the loop, otherwise a skipped assignment infers a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = REQ_W'((int'(rr_ptr) + k) % N_REQ);
      if (!empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    winner = fifo_head[0];
    for (int i = 1; i < N_REQ; i++) begin
      if (grant_idx == REQ_W'(i)) winner = fifo_head[i];
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (grant_valid) begin
      rr_next = (grant_idx == REQ_W'(N_REQ - 1)) ? '0 : grant_idx + REQ_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      cdb.valid <= 1'b0;
      cdb.label <= '0;
      cdb.data  <= '0;
    end else if (flush) begin
      rr_ptr    <= '0;
      cdb.valid <= 1'b0;
    end else begin
      rr_ptr    <= rr_next;
      cdb.valid <= grant_valid;
      if (grant_valid) begin
        cdb.label <= winner.label;
        cdb.data  <= winner.data;
      end
    end
  end

  // A tag may be broadcast again only after it has been pushed again.
  always_comb begin
    label_pend_next = label_pend;
    if (cdb.valid) label_pend_next[cdb.label] = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (push[i]) label_pend_next[req_label[i]] = 1'b1;
    end
    if (flush) label_pend_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) label_pend <= '0;
    else        label_pend <= label_pend_next;
  end

  a_no_dup_broadcast : assert property (@(posedge clk) disable iff (!rst_n)
    cdb.valid |-> label_pend[cdb.label]);

endmodule
